apb_slave_regs: RTL and testbench

- APB completer that sits directly downstream of the AHB-to-APB bridge; one instance per PSELx bit.
- Implements a small memory-mapped register bank: 6 RW scratch/control registers, 1 RO ID register, 1 RO transfer counter.
- Provides programmable wait states via PREADY and error signalling via PSLVERR.
- WAIT_STATES=0 is mandatory when the instance is driven by the current bridge, which does not yet sample PREADY.

---
 rtl/apb_slave_pkg.sv | 19 +
 rtl/apb_wait_ctr.sv | 21 ++
 rtl/apb_slave_regs.sv | 109 ++++++++++
 tb/tb_apb_slave_regs.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared constants and types for the APB register-bank completer.
package apb_slave_pkg;

  localparam int NUM_RW = 6;

  localparam logic [4:0] REG0    = 5'h00;
  localparam logic [4:0] REG1    = 5'h04;
  localparam logic [4:0] REG2    = 5'h08;
  localparam logic [4:0] REG3    = 5'h0C;
  localparam logic [4:0] REG4    = 5'h10;
  localparam logic [4:0] REG5    = 5'h14;
  localparam logic [4:0] ID_OFF  = 5'h18;
  localparam logic [4:0] CNT_OFF = 5'h1C;

  localparam logic [31:0] DEFAULT_ID = 32'hA2B0_0001;

  typedef enum logic {IDLE, ACCESS} state_e;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable 4-bit down-counter that counts out access-phase wait states.
module apb_wait_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt_q <= 4'd0;
    else if (load)               cnt_q <= load_val;
    else if (en && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer: six RW registers, RO ID and RO transfer counter, with
// programmable wait states and PSLVERR on bad address / RO writes.
module apb_slave_regs
  import apb_slave_pkg::*;
#(
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID,
  parameter logic [31:0] RW_RESET    = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [15:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] ctrl_out
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [31:0] rw_q [NUM_RW];
  logic [31:0] xfer_cnt_q;
  logic [31:0] rdata_mux;
  logic        setup, access_ph, wait_zero, ctr_load;
  logic        ready_int, violation, err, wr_commit;

  assign setup     = PSEL && !PENABLE;
  assign access_ph = PSEL && PENABLE;
  assign err       = (PADDR[1:0] != 2'b00) || (PADDR[15:5] != 11'd0) ||
                     (PWRITE && (PADDR[4:0] == ID_OFF || PADDR[4:0] == CNT_OFF));

  apb_wait_ctr u_wait (
    .clk      (HCLK),
    .rst      (HRESET),
    .load     (ctr_load),
    .load_val (WS),
    .en       (state_q == ACCESS),
    .zero     (wait_zero)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ctr_load  = 1'b0;
    ready_int = 1'b0;
    violation = 1'b0;
    case (state_q)
      IDLE: begin
        // Enable without a setup cycle: complete with error so the master cannot hang.
        violation = access_ph;
        if (setup) begin
          state_d  = ACCESS;
          ctr_load = 1'b1;
        end
      end
      ACCESS: begin
        ready_int = access_ph && wait_zero;
        if (!PSEL || ready_int) state_d = IDLE;
        else if (setup)         ctr_load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    PREADY  = !HRESET && (ready_int || violation);
    PSLVERR = !HRESET && ((ready_int && err) || violation);
    PRDATA  = (!HRESET && ready_int && !PWRITE && !err) ? rdata_mux : 32'd0;
  end

  assign wr_commit = ready_int && PWRITE && !err;

  always_comb begin
    rdata_mux = 32'd0;
    case (PADDR[4:0])
      REG0:    rdata_mux = rw_q[0];
      REG1:    rdata_mux = rw_q[1];
      REG2:    rdata_mux = rw_q[2];
      REG3:    rdata_mux = rw_q[3];
      REG4:    rdata_mux = rw_q[4];
      REG5:    rdata_mux = rw_q[5];
      ID_OFF:  rdata_mux = ID_VALUE;
      CNT_OFF: rdata_mux = xfer_cnt_q;
      default: rdata_mux = 32'd0;
    endcase
  end

  for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)                                 rw_q[i] <= RW_RESET;
      else if (wr_commit && PADDR[4:2] == 3'(i)) rw_q[i] <= PWDATA;
    end
  end

  // Counts every completion, errored or not; reads see the pre-increment value.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)         xfer_cnt_q <= 32'd0;
    else if (ready_int) xfer_cnt_q <= xfer_cnt_q + 32'd1;
  end

  assign ctrl_out = rw_q[0];

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench: two completers (0 and 3 wait states) on one shared APB bus.
module tb_apb_slave_regs;

  logic        HCLK = 1'b0, HRESET = 1'b1;
  logic        psel0 = 1'b0, psel3 = 1'b0;
  logic        PENABLE = 1'b0, PWRITE = 1'b0;
  logic [15:0] PADDR = 16'd0;
  logic [31:0] PWDATA = 32'd0;
  logic [31:0] prdata0, prdata3, ctrl0, ctrl3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int n_cmp = 0, n_err = 0;

  apb_slave_regs #(.WAIT_STATES(0)) u0 (
    .HCLK(HCLK), .HRESET(HRESET), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .ctrl_out(ctrl0));

  apb_slave_regs #(.WAIT_STATES(3)) u3 (
    .HCLK(HCLK), .HRESET(HRESET), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata3), .PREADY(pready3),
    .PSLVERR(pslverr3), .ctrl_out(ctrl3));

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full setup+access transfer on one instance; reports data/error/wait count.
  task automatic xfer(input bit i3, input bit wr, input logic [15:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic se, output int waits, output logic [31:0] cp);
    @(posedge HCLK); #1;
    psel0 = !i3; psel3 = i3; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    waits = 0; rd = 'x; se = 1'bx; cp = 'x;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK);
      if ((i3 ? pready3 : pready0) === 1'b1) begin
        rd = i3 ? prdata3 : prdata0;
        se = i3 ? pslverr3 : pslverr0;
        cp = i3 ? ctrl3 : ctrl0;
        break;
      end
      waits++;
    end
    if (waits >= 20) begin
      n_cmp++; n_err++;
      $error("FAIL timeout: observed no PREADY after %0d cycles, expected completion", waits);
    end
    @(posedge HCLK); #1;
    psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, cp;
    logic        se;
    int          w;

    @(negedge HCLK);
    chk("rst_prdata", prdata0, 32'd0);
    chk("rst_pready", {31'd0, pready0}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr0}, 32'd0);
    chk("rst_ctrl", ctrl0, 32'd0);
    @(posedge HCLK); #1; HRESET = 1'b0;

    // Zero-wait instance: ID and counter reads
    xfer(0, 0, 16'h001C, 0, rd, se, w, cp);
    chk("cnt0", rd, 32'd0); chk("cnt0_waits", w, 32'd0);
    xfer(0, 0, 16'h0018, 0, rd, se, w, cp);
    chk("id", rd, 32'hA2B0_0001); chk("id_err", {31'd0, se}, 32'd0);
    chk("id_waits", w, 32'd0);

    xfer(0, 1, 16'h0000, 32'hDEAD_BEEF, rd, se, w, cp);
    chk("wr0_err", {31'd0, se}, 32'd0);
    chk("ctrl_pre", cp, 32'd0);
    chk("ctrl_post", ctrl0, 32'hDEAD_BEEF);
    xfer(0, 0, 16'h0000, 0, rd, se, w, cp);
    chk("rd0", rd, 32'hDEAD_BEEF);
    xfer(0, 0, 16'h001C, 0, rd, se, w, cp);
    chk("cnt4", rd, 32'd4);

    // Error cases
    xfer(0, 1, 16'h0018, 32'h0000_0055, rd, se, w, cp);
    chk("wr_id_err", {31'd0, se}, 32'd1);
    xfer(0, 0, 16'h0018, 0, rd, se, w, cp);
    chk("id_kept", rd, 32'hA2B0_0001);
    xfer(0, 0, 16'h0002, 0, rd, se, w, cp);
    chk("misal_err", {31'd0, se}, 32'd1); chk("misal_data", rd, 32'd0);
    xfer(0, 0, 16'h0020, 0, rd, se, w, cp);
    chk("hiaddr_err", {31'd0, se}, 32'd1); chk("hiaddr_data", rd, 32'd0);
    xfer(0, 0, 16'h001C, 0, rd, se, w, cp);
    chk("cnt9", rd, 32'd9); chk("cnt9_err", {31'd0, se}, 32'd0);

    // Enable without setup while idle
    @(posedge HCLK); #1;
    psel0 = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 16'h0000; PWDATA = 32'h1111_1111;
    @(negedge HCLK);
    chk("viol_ready", {31'd0, pready0}, 32'd1);
    chk("viol_err", {31'd0, pslverr0}, 32'd1);
    @(posedge HCLK); #1; psel0 = 1'b0; PENABLE = 1'b0;
    xfer(0, 0, 16'h0000, 0, rd, se, w, cp);
    chk("viol_nowr", rd, 32'hDEAD_BEEF);
    xfer(0, 0, 16'h001C, 0, rd, se, w, cp);
    chk("viol_nocnt", rd, 32'd11);

    // Counter wrap
    force u0.xfer_cnt_q = 32'hFFFF_FFFF;
    #1 release u0.xfer_cnt_q;
    xfer(0, 0, 16'h001C, 0, rd, se, w, cp);
    chk("cnt_max", rd, 32'hFFFF_FFFF);
    xfer(0, 0, 16'h001C, 0, rd, se, w, cp);
    chk("cnt_wrap", rd, 32'd0);

    // Three-wait instance
    xfer(1, 1, 16'h0014, 32'h1234_5678, rd, se, w, cp);
    chk("ws3_wr_waits", w, 32'd3); chk("ws3_wr_err", {31'd0, se}, 32'd0);
    xfer(1, 0, 16'h0014, 0, rd, se, w, cp);
    chk("ws3_rd", rd, 32'h1234_5678); chk("ws3_rd_waits", w, 32'd3);

    // Abort after one access cycle
    @(posedge HCLK); #1;
    psel3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0004; PWDATA = 32'hAAAA_5555;
    @(posedge HCLK); #1; PENABLE = 1'b1;
    @(negedge HCLK);
    chk("abort_wait", {31'd0, pready3}, 32'd0);
    @(posedge HCLK); #1; psel3 = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK);
    chk("abort_ready", {31'd0, pready3}, 32'd0);
    chk("abort_err", {31'd0, pslverr3}, 32'd0);
    xfer(1, 0, 16'h0004, 0, rd, se, w, cp);
    chk("abort_nowr", rd, 32'd0); chk("abort_next_waits", w, 32'd3);
    xfer(1, 0, 16'h001C, 0, rd, se, w, cp);
    chk("abort_nocnt", rd, 32'd3);

    // Async reset in the middle of an access
    force u3.xfer_cnt_q = 32'hFFFF_FFFF;
    #1 release u3.xfer_cnt_q;
    @(posedge HCLK); #1;
    psel3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0000; PWDATA = 32'h0000_0001;
    @(posedge HCLK); #1; PENABLE = 1'b1;
    #2 HRESET = 1'b1;
    #1;
    chk("arst_prdata", prdata3, 32'd0);
    chk("arst_pready", {31'd0, pready3}, 32'd0);
    chk("arst_pslverr", {31'd0, pslverr3}, 32'd0);
    chk("arst_ctrl0", ctrl0, 32'd0);
    psel3 = 1'b0; PENABLE = 1'b0;
    @(posedge HCLK); #1; HRESET = 1'b0;
    xfer(1, 0, 16'h0014, 0, rd, se, w, cp);
    chk("arst_reg5", rd, 32'd0);
    xfer(1, 0, 16'h0000, 0, rd, se, w, cp);
    chk("arst_reg0", rd, 32'd0);
    xfer(1, 0, 16'h001C, 0, rd, se, w, cp);
    chk("arst_cnt", rd, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
